// File: rtl/spart_bus_arbiter_if.sv
`default_nettype none
// =============================================================================
// spart_bus_arbiter_if: requester handshake plus SPART control/status signals
// Revision: 1.0
// =============================================================================
interface spart_bus_arbiter_if;
  logic [1:0] req;
  logic [1:0] we;
  logic [1:0] addr0;
  logic [1:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [1:0] done;
  logic [7:0] rdata;
  logic       lock_err;
  logic       rda;
  logic       tbr;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;

  // Environment side: the requesters together with the SPART status lines.
  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, rda, tbr,
    input  done, rdata, lock_err, iocs, iorw, ioaddr
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, rda, tbr,
    output done, rdata, lock_err, iocs, iorw, ioaddr
  );
endinterface
`default_nettype wire

// File: rtl/spart_bus_arbiter.sv
`default_nettype none
// =============================================================================
// spart_bus_arbiter: round-robin arbiter for the SPART bus with divisor lock
// Revision: 1.0
// =============================================================================
module spart_bus_arbiter #(
  parameter int LOCK_TIMEOUT = 16
) (
  input  wire                clk,
  input  wire                rst_n,
  spart_bus_arbiter_if.slave bus,
  inout  wire [7:0]          databus
);
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  localparam logic [7:0] C_TIMEOUT = 8'(LOCK_TIMEOUT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_win;
  logic       r_we;
  logic [1:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic       r_last_grant;
  logic       r_lock;
  logic       r_owner;
  logic [7:0] r_lock_cnt;
  logic       r_lock_err;

  logic [1:0] w_addr [2];
  logic [1:0] w_elig;
  logic       w_grant;
  logic       w_win;
  logic       w_win_we;
  logic [1:0] w_win_addr;
  logic [7:0] w_win_wdata;
  logic [7:0] w_cnt_inc;
  logic       w_iocs;
  logic       w_iorw;
  logic [1:0] w_ioaddr;
  logic       w_drive;
  logic [1:0] w_done;
  logic       w_unlock;

  assign w_addr[0] = bus.addr0;
  assign w_addr[1] = bus.addr1;

  // While locked only the owner's DB-high write may proceed.
  for (genvar gi = 0; gi < 2; gi++) begin : g_elig
    logic w_open;
    logic w_lock_ok;
    assign w_open    = (w_addr[gi] != 2'b00) | (bus.we[gi] ? bus.tbr : bus.rda);
    assign w_lock_ok = (r_owner == (gi == 1)) & bus.we[gi] & (w_addr[gi] == 2'b11);
    assign w_elig[gi] = bus.req[gi] & (r_lock ? w_lock_ok : w_open);
  end

  assign w_grant     = (r_state == ST_IDLE) & (|w_elig);
  assign w_win       = (w_elig == 2'b11) ? ~r_last_grant : w_elig[1];
  assign w_win_we    = w_win ? bus.we[1]  : bus.we[0];
  assign w_win_addr  = w_win ? bus.addr1  : bus.addr0;
  assign w_win_wdata = w_win ? bus.wdata1 : bus.wdata0;
  assign w_cnt_inc   = r_lock_cnt + 8'd1;
  assign w_unlock    = (r_state == ST_COMPLETE) & r_lock & r_we &
                       (r_addr == 2'b11) & (r_win == r_owner);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_iocs      = 1'b0;
    w_iorw      = 1'b1;
    w_ioaddr    = 2'b00;
    w_drive     = 1'b0;
    w_done      = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_COMPLETE;
        w_iocs      = 1'b1;
        w_iorw      = ~r_we;
        w_ioaddr    = r_addr;
        w_drive     = r_we;
      end
      ST_COMPLETE: begin
        w_state_nxt = ST_IDLE;
        w_done      = r_win ? 2'b10 : 2'b01;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 2'b00;
      r_wdata      <= 8'h00;
      r_rdata      <= 8'h00;
      r_last_grant <= 1'b1;
      r_lock       <= 1'b0;
      r_owner      <= 1'b0;
      r_lock_cnt   <= 8'h00;
      r_lock_err   <= 1'b0;
    end else begin
      r_lock_err <= 1'b0;
      if (w_grant) begin
        r_win        <= w_win;
        r_we         <= w_win_we;
        r_addr       <= w_win_addr;
        r_wdata      <= w_win_wdata;
        r_last_grant <= w_win;
      end
      if ((r_state == ST_ACCESS) && !r_we) begin
        r_rdata <= databus;
      end
      if (w_grant && w_win_we && (w_win_addr == 2'b10)) begin
        r_lock     <= 1'b1;
        r_owner    <= w_win;
        r_lock_cnt <= 8'h00;
      end else if (w_unlock) begin
        r_lock <= 1'b0;
      end else if (r_lock && (r_state == ST_IDLE)) begin
        // Any grant while locked belongs to the owner and restarts the wait.
        if (w_grant) begin
          r_lock_cnt <= 8'h00;
        end else if (w_cnt_inc == C_TIMEOUT) begin
          r_lock     <= 1'b0;
          r_lock_err <= 1'b1;
          r_lock_cnt <= 8'h00;
        end else begin
          r_lock_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign bus.iocs     = w_iocs;
  assign bus.iorw     = w_iorw;
  assign bus.ioaddr   = w_ioaddr;
  assign bus.done     = w_done;
  assign bus.rdata    = r_rdata;
  assign bus.lock_err = r_lock_err;
  assign databus      = w_drive ? r_wdata : 8'bz;
endmodule
`default_nettype wire

// File: doc/spart_bus_arbiter.md
# spart_bus_arbiter

Shares the single SPART processor-side bus (iocs/iorw/ioaddr/databus) between two requesters, e.g. the echo driver and a message/debug engine. Each requester issues single-byte transactions over a req/done handshake; the arbiter grants round-robin, gates TX writes on tbr and RX reads on rda, and locks the bus across the two-byte baud-divisor write so divisor bytes from different requesters never interleave. It sits directly between the requesters and the SPART bus port.

## Interface
- LOCK_TIMEOUT, 16: idle cycles a lock owner may wait before issuing its addr 11 write; on expiry the lock is dropped (range 2..255)
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low; clock clk
- req[1:0]  in  2  per-requester request; held stable with its fields until that requester's done
- we[1:0]  in  2  1 = write, 0 = read
- addr0, addr1  in  2 each  SPART register address (00 TX/RX, 01 status, 10 DB low, 11 DB high)
- wdata0, wdata1  in  8 each  write data
- done[1:0]  out  2  one-cycle completion pulse to the granted requester
- rdata  out  8  read data, valid in the cycle done pulses
- lock_err  out  1  one-cycle pulse when a lock times out
- rda, tbr  in  1 each  SPART receive-data-available / transmit-buffer-ready
- iocs, iorw  out  1 each  SPART chip select; 1 = read, 0 = write
- ioaddr  out  2  SPART register address
- databus  inout  8  driven only during a granted write access, else high-Z

## Operation
- States: IDLE, ACCESS, COMPLETE. IDLE -> ACCESS when an eligible request exists; ACCESS -> COMPLETE always; COMPLETE -> IDLE always.
- Eligibility of requester i (evaluated in IDLE only): req[i]=1 and
  - addr 00 write: tbr=1; addr 00 read: rda=1; addr 01/10/11: always.
  - While locked: only the lock owner is eligible, and only for a write to addr 11.
- Winner selection: one eligible -> it wins. Both eligible -> requester != last_grant wins. last_grant updates on every grant.
- On grant: latch winner index, we, addr, wdata into registers; later changes on requester inputs do not affect the access.
- ACCESS: iocs=1, ioaddr=latched addr, iorw=~latched we; databus=latched wdata for writes, high-Z for reads; reads capture databus into rdata at the end of the cycle.
- COMPLETE: done[winner]=1; rdata holds the captured byte (unchanged on writes).
- Lock: a granted write to addr 10 sets lock, owner=winner. The owner's granted write to addr 11 clears lock when it reaches COMPLETE. A read, or a write to 00/01, by the owner is ineligible while locked.
- Lock timeout: an 8-bit counter clears when lock is set and on every owner grant, increments each cycle the arbiter is locked and in IDLE. When it reaches LOCK_TIMEOUT: clear lock, pulse lock_err for one cycle, reset the counter; the other requester becomes eligible the following cycle.
- Outside ACCESS: iocs=0, iorw=1, ioaddr=00, databus high-Z.

## Timing
- Reset values: iocs 0, iorw 1, ioaddr 00, databus Z, done 00, rdata 00, lock_err 0, state IDLE, lock clear, last_grant 1 (requester 0 wins the first contention).
- Request eligible in IDLE cycle N -> bus access in N+1 -> done and rdata in N+2 -> IDLE in N+3. Earliest next grant is evaluated in N+3. Peak throughput is 1 transaction per 3 cycles.
- rda/tbr are sampled only in IDLE. A deassertion during ACCESS/COMPLETE does not abort the access.
- A requester that drops req before its grant is simply not served. Dropping req after the grant does not cancel the access.
- An asserted rst_n mid-access aborts immediately: iocs drops and databus releases asynchronously, no done is issued, and the lock is cleared.

## Test plan
- Single write: req0, we=1, addr=00, wdata=0x41, tbr=1 -> iocs=1/iorw=0/ioaddr=00/databus=0x41 for exactly one cycle; done=01 two cycles after the request; databus Z otherwise.
- RX gating: req1 read addr 00 with rda=0 for 10 cycles -> iocs stays 0. Raise rda -> access the next cycle, databus=0x5A sampled, rdata=0x5A with done=10.
- Round-robin: both requesters hold status reads (addr 01) continuously -> grant order 0,1,0,1. Each done is separated by 3 cycles.
- Lock: req0 writes addr 10=0x8B. Then req1 (addr 01 read) and req0 (addr 11=0x02) both request -> req0 served first, req1 after. ioaddr sequence is 10, 11, 01.
- Lock timeout (LOCK_TIMEOUT=16): req0 writes addr 10, then idles while req1 requests -> lock_err pulses once, and req1 is granted the cycle after.
- Reset: assert rst_n low during ACCESS of a write -> iocs=0, databus Z, done=00 immediately. After release, the first contention goes to requester 0.
